// File: rtl/norm_writer.sv
`default_nettype none
// ============================================================================
// Module   : norm_writer
// Purpose  : Captures one cropped frame (OUT_ROWS*OUT_COLS 8-bit pixels) from
//            the crop stream into an internal RAM while tracking the largest
//            pixel. Publishes that maximum as the normalization denominator
//            (forced to 1 for an all-zero frame), then replays the stored
//            pixels in arrival order on an AXI-Stream master.
// Ports    : clk, reset_n (sync, active-low)
//            ap_start / ap_ready / ap_idle / ap_done   - block-level handshake
//            s_axis_tvalid / s_axis_tready / s_axis_tdata  - crop stream in
//            norm_denominator / norm_denominator_tvalid    - frame maximum
//            m_axis_tvalid / m_axis_tready / m_axis_tdata  - replay stream out
// Revision : 1.0 - initial release
// ============================================================================
module norm_writer #(
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ap_start,
  output logic       ap_ready,
  output logic       ap_idle,
  output logic       ap_done,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic [7:0] s_axis_tdata,
  output logic [7:0] norm_denominator,
  output logic       norm_denominator_tvalid,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic [7:0] m_axis_tdata
);

  localparam int N  = OUT_ROWS * OUT_COLS;
  localparam int CW = $clog2(N + 1);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_PUBLISH = 3'd2,
    S_STREAM  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [7:0]      max_q, max_d;
  logic [7:0]      den_q, den_d;
  logic [7:0]      rdata_q;

  logic            wr_en;
  logic            rd_en;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic            s_beat;
  logic            m_beat;
  logic [7:0]      beat_max;

  logic [7:0]      pix_mem [N];

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    max_d    = max_q;
    den_d    = den_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    wr_addr  = wr_cnt_q[AW-1:0];
    s_beat   = s_axis_tvalid && (state_q == S_CAPTURE);
    m_beat   = m_axis_tready && (state_q == S_STREAM);
    // Running maximum including the pixel on the current beat, so the
    // denominator captured on the final beat already accounts for it.
    beat_max = (s_axis_tdata > max_q) ? s_axis_tdata : max_q;

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d  = S_CAPTURE;
          wr_cnt_d = '0;
          max_d    = '0;
        end
      end
      S_CAPTURE: begin
        if (s_beat) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + CW'(1);
          max_d    = beat_max;
          if (wr_cnt_q == C_LAST) begin
            state_d = S_PUBLISH;
            den_d   = (beat_max == 8'd0) ? 8'd1 : beat_max;
          end
        end
      end
      S_PUBLISH: begin
        // Prime the read register with pixel 0 so it is presented on the
        // very first STREAM cycle.
        rd_en    = 1'b1;
        rd_addr  = '0;
        rd_cnt_d = '0;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        // The read register doubles as the output register: it is only
        // reloaded on a handshake, so data holds during a stall and the next
        // pixel is ready one cycle later with no bubble.
        if (m_beat) begin
          if (rd_cnt_q == C_LAST) begin
            state_d = S_DONE;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
            rd_en    = 1'b1;
            rd_addr  = rd_cnt_d[AW-1:0];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      max_q    <= '0;
      den_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      max_q    <= max_d;
      den_q    <= den_d;
    end
  end

  // Frame buffer: one write port, one synchronous read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pix_mem[wr_addr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= pix_mem[rd_addr];
    end
  end

  assign ap_idle                 = (state_q == S_IDLE);
  assign ap_ready                = (state_q == S_IDLE);
  assign ap_done                 = (state_q == S_DONE);
  assign s_axis_tready           = (state_q == S_CAPTURE);
  assign m_axis_tvalid           = (state_q == S_STREAM);
  assign norm_denominator_tvalid = (state_q == S_PUBLISH) || (state_q == S_STREAM) ||
                                   (state_q == S_DONE);
  assign norm_denominator        = den_q;
  assign m_axis_tdata            = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_norm_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_norm_writer
// Purpose  : Self-checking bench for norm_writer. Each frame is compared
//            against a reference built from the frame's pixel list: expected
//            denominator is the list maximum (1 when zero), expected output is
//            the list itself in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_norm_writer;

  localparam int N = 100;

  logic       clk;
  logic       reset_n;
  logic       ap_start;
  logic       ap_ready;
  logic       ap_idle;
  logic       ap_done;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata;
  logic [7:0] norm_denominator;
  logic       norm_denominator_tvalid;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] m_axis_tdata;

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;
  logic done_prev = 1'b0;
  logic [7:0] in_q [$];

  norm_writer #(.OUT_ROWS(10), .OUT_COLS(10)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .ap_start                (ap_start),
    .ap_ready                (ap_ready),
    .ap_idle                 (ap_idle),
    .ap_done                 (ap_done),
    .s_axis_tvalid           (s_axis_tvalid),
    .s_axis_tready           (s_axis_tready),
    .s_axis_tdata            (s_axis_tdata),
    .norm_denominator        (norm_denominator),
    .norm_denominator_tvalid (norm_denominator_tvalid),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .m_axis_tdata            (m_axis_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ap_done === 1'b1 && done_prev !== 1'b1) done_pulses = done_pulses + 1;
    done_prev = ap_done;
  end

  // Checks every output against its reset value; caller is at a negedge.
  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({ap_ready, ap_idle, ap_done, s_axis_tready, m_axis_tvalid,
         norm_denominator_tvalid} !== 6'b110000) begin
      errors++;
      $display("FAIL %s_ctrl: got %b expected 110000", tag,
               {ap_ready, ap_idle, ap_done, s_axis_tready, m_axis_tvalid,
                norm_denominator_tvalid});
    end
    checks++;
    if (norm_denominator !== 8'd0) begin
      errors++;
      $display("FAIL %s_den: got %0d expected 0", tag, norm_denominator);
    end
    checks++;
    if (m_axis_tdata !== 8'd0) begin
      errors++;
      $display("FAIL %s_tdata: got %0d expected 0", tag, m_axis_tdata);
    end
  endtask

  // Runs one frame from in_q. Starts and ends at a negedge with the DUT idle.
  task automatic run_frame(input bit rand_valid, input bit pat_ready,
                           input bit hold_start, input bit full_rate);
    int sent, rcv, cyc, t_last, first_out, last_out, done_cyc;
    logic [7:0] exp_max, exp_den, prev_data;
    bit prev_v, prev_r;

    exp_max = 8'd0;
    foreach (in_q[i]) if (in_q[i] > exp_max) exp_max = in_q[i];
    exp_den = (exp_max == 8'd0) ? 8'd1 : exp_max;

    checks++;
    if (ap_idle !== 1'b1 || ap_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_idle: got idle=%b ready=%b expected 1", ap_idle, ap_ready);
    end
    ap_start = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    @(negedge clk);
    ap_start = hold_start;

    sent = 0; rcv = 0; cyc = 0; t_last = -10;
    first_out = -1; last_out = -1; done_cyc = -1;
    prev_v = 1'b0; prev_r = 1'b0; prev_data = 8'd0;

    while (1) begin
      if (cyc == t_last + 1) begin
        checks++;
        if (norm_denominator_tvalid !== 1'b1 || norm_denominator !== exp_den ||
            m_axis_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL denom_T+1: got dv=%b den=%0d mv=%b expected dv=1 den=%0d mv=0",
                   norm_denominator_tvalid, norm_denominator, m_axis_tvalid, exp_den);
        end
      end
      if (cyc == t_last + 2) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || rcv != 0) begin
          errors++;
          $display("FAIL first_out_T+2: got mv=%b rcv=%0d expected mv=1 rcv=0",
                   m_axis_tvalid, rcv);
        end
      end
      if (m_axis_tvalid === 1'b1) begin
        checks++;
        if (norm_denominator_tvalid !== 1'b1) begin
          errors++;
          $display("FAIL valid_order: got denom_tvalid=%b expected 1", norm_denominator_tvalid);
        end
      end
      if (prev_v && !prev_r) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: got mv=%b data=%0d expected mv=1 data=%0d",
                   m_axis_tvalid, m_axis_tdata, prev_data);
        end
      end
      if (sent == N) begin
        checks++;
        if (s_axis_tready !== 1'b0) begin
          errors++;
          $display("FAIL s_tready_after_frame: got %b expected 0", s_axis_tready);
        end
      end
      if (ap_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (cyc >= 3000) begin
        checks++;
        errors++;
        $display("FAIL frame_timeout: got sent=%0d rcv=%0d expected ap_done within 3000 cycles",
                 sent, rcv);
        break;
      end

      // Upstream driver: keeps offering junk after the frame to expose any
      // extra acceptance.
      if (sent < N) begin
        s_axis_tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        s_axis_tdata  = in_q[sent];
      end else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'hEE;
      end
      if (sent < N && s_axis_tvalid && s_axis_tready === 1'b1) begin
        if (sent == N - 1) t_last = cyc;
        sent++;
      end

      // Downstream sink.
      m_axis_tready = pat_ready ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
        checks++;
        if (rcv >= N) begin
          errors++;
          $display("FAIL extra_beat: got beat %0d expected at most %0d", rcv + 1, N);
        end else if (m_axis_tdata !== in_q[rcv]) begin
          errors++;
          $display("FAIL out_data[%0d]: got %0d expected %0d", rcv, m_axis_tdata, in_q[rcv]);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        rcv++;
      end
      prev_v    = (m_axis_tvalid === 1'b1);
      prev_r    = m_axis_tready;
      prev_data = m_axis_tdata;

      @(negedge clk);
      cyc++;
    end

    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;

    checks++;
    if (rcv != N) begin
      errors++;
      $display("FAIL beat_count: got %0d expected %0d", rcv, N);
    end
    checks++;
    if (done_cyc != last_out + 1) begin
      errors++;
      $display("FAIL done_timing: got cycle %0d expected %0d", done_cyc, last_out + 1);
    end
    if (full_rate) begin
      checks++;
      if (first_out != t_last + 2 || last_out - first_out != N - 1) begin
        errors++;
        $display("FAIL full_rate: got first=%0d span=%0d expected first=%0d span=%0d",
                 first_out, last_out - first_out, t_last + 2, N - 1);
      end
    end

    @(negedge clk);
    checks++;
    if (ap_done !== 1'b0 || ap_idle !== 1'b1 || norm_denominator_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got done=%b idle=%b dv=%b expected 0 1 0",
               ap_done, ap_idle, norm_denominator_tvalid);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    ap_start = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = 8'd0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
  endtask

  task automatic test_ramp;
    in_q.delete();
    for (int i = 0; i < N; i++) in_q.push_back(8'(i));
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_all_zero;
    in_q.delete();
    for (int i = 0; i < N; i++) in_q.push_back(8'd0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_max_last;
    in_q.delete();
    for (int i = 0; i < N - 1; i++) in_q.push_back(8'd5);
    in_q.push_back(8'd250);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random_stalls;
    in_q.delete();
    for (int i = 0; i < N; i++) in_q.push_back(8'($urandom_range(0, 255)));
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset;
    int sent;
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    sent = 0;
    while (sent < 40) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = (sent == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      if (s_axis_tready === 1'b1) sent++;
      @(negedge clk);
      if (sent == 0) begin
        checks++;
        errors++;
        $display("FAIL mid_capture: got tready=%b expected 1", s_axis_tready);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_reset_outputs("mid_reset");
    in_q.delete();
    for (int i = 0; i < N; i++) in_q.push_back(8'($urandom_range(10, 199)));
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_held;
    int d0;
    d0 = done_pulses;
    in_q.delete();
    for (int i = 0; i < N; i++) in_q.push_back(8'($urandom_range(0, 120)));
    run_frame(1'b0, 1'b1, 1'b1, 1'b0);
    in_q.delete();
    for (int i = 0; i < N; i++) in_q.push_back(8'($urandom_range(0, 255)));
    run_frame(1'b1, 1'b0, 1'b1, 1'b0);
    ap_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_pulses - d0 != 2 || ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL two_frames_done: got pulses=%0d idle=%b expected 2 1",
               done_pulses - d0, ap_idle);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_all_zero();
    test_max_last();
    test_random_stalls();
    test_mid_reset();
    test_start_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
